// File: rtl/imm_encode.sv
// ---------------------------------------------------------------------------
// imm_encode
//   Two-stage valid/ready pipeline that packs a signed immediate into the
//   immediate fields of a RISC-V instruction word (bits [31:7]) taken from a
//   template, and flags immediates that cannot be represented.
//
//   S1 captures the request and evaluates the range/alignment checks.
//   S2 packs the immediate into the template and drives the outputs.
//
// Ports
//   clk        rising-edge clock for all state
//   reset      synchronous active-high reset
//   in_valid   request beat present
//   in_ready   beat accepted this cycle
//   immsrc     format select: 00 I, 01 S, 10 B, 11 J
//   imm        signed immediate (byte offset for B/J)
//   base       instr[31:7] template; non-immediate bits pass through
//   out_valid  encoded beat present
//   out_ready  consumer accepts beat
//   instr      encoded instr[31:7] (instr[k] appears on bit k-7)
//   err_range  immediate not representable (qualified by out_valid)
//   err_align  B/J immediate odd (qualified by out_valid)
//   err_count  saturating count of errored beats delivered
// ---------------------------------------------------------------------------
module imm_encode #(
  parameter int CNTWIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          immsrc,
  input  logic [31:0]         imm,
  input  logic [24:0]         base,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [24:0]         instr,
  output logic                err_range,
  output logic                err_align,
  output logic [CNTWIDTH-1:0] err_count
);

  localparam logic [1:0] FMT_I = 2'b00;
  localparam logic [1:0] FMT_S = 2'b01;
  localparam logic [1:0] FMT_B = 2'b10;

  // Stage 1 state. Only imm[20:0] is ever packed, so the upper bits are
  // consumed by the range check at capture time and not stored.
  logic        s1_valid_reg;
  logic [1:0]  s1_src_reg;
  logic [20:0] s1_imm_reg;
  logic [24:0] s1_base_reg;
  logic        s1_erange_reg;
  logic        s1_ealign_reg;

  // Stage 2 state (drives the outputs directly)
  logic        s2_valid_reg;
  logic [24:0] s2_instr_reg;
  logic        s2_erange_reg;
  logic        s2_ealign_reg;

  logic [CNTWIDTH-1:0] cnt_reg;

  logic        s1_advance;
  logic        s2_advance;
  logic        in_fire;
  logic        range_ok;
  logic        align_err;
  logic [24:0] instr_next;

  assign s2_advance = s2_valid_reg & out_ready;
  assign s1_advance = s1_valid_reg & (~s2_valid_reg | out_ready);
  // Held low during reset so nothing is accepted into a pipeline being flushed.
  assign in_ready   = ~reset & (~s1_valid_reg | s1_advance);
  assign in_fire    = in_valid & in_ready;

  // Representable when every bit above the field's sign bit matches it.
  always_comb begin
    range_ok = 1'b1;
    case (immsrc)
      FMT_I, FMT_S: range_ok = (&imm[31:11]) | ~(|imm[31:11]);
      FMT_B:        range_ok = (&imm[31:12]) | ~(|imm[31:12]);
      default:      range_ok = (&imm[31:20]) | ~(|imm[31:20]);
    endcase
  end

  // B/J offsets are halfword multiples; bit 0 is dropped when packing.
  assign align_err = immsrc[1] & imm[0];

  // Field packing. Index k here corresponds to instruction bit k+7.
  always_comb begin
    instr_next = s1_base_reg;
    case (s1_src_reg)
      FMT_I: begin
        instr_next[24:13] = s1_imm_reg[11:0];
      end
      FMT_S: begin
        instr_next[24:18] = s1_imm_reg[11:5];
        instr_next[4:0]   = s1_imm_reg[4:0];
      end
      FMT_B: begin
        instr_next[24]    = s1_imm_reg[12];
        instr_next[23:18] = s1_imm_reg[10:5];
        instr_next[4:1]   = s1_imm_reg[4:1];
        instr_next[0]     = s1_imm_reg[11];
      end
      default: begin
        instr_next[24]    = s1_imm_reg[20];
        instr_next[23:14] = s1_imm_reg[10:1];
        instr_next[13]    = s1_imm_reg[11];
        instr_next[12:5]  = s1_imm_reg[19:12];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg  <= 1'b0;
      s2_valid_reg  <= 1'b0;
      s2_erange_reg <= 1'b0;
      s2_ealign_reg <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      s1_valid_reg <= in_fire | (s1_valid_reg & ~s1_advance);
      s2_valid_reg <= s1_advance | (s2_valid_reg & ~out_ready);

      if (in_fire) begin
        s1_src_reg    <= immsrc;
        s1_imm_reg    <= imm[20:0];
        s1_base_reg   <= base;
        s1_erange_reg <= ~range_ok;
        s1_ealign_reg <= align_err;
      end

      // S2 only loads when its current beat has left (or it was empty),
      // which keeps the outputs stable under backpressure.
      if (s1_advance) begin
        s2_instr_reg  <= instr_next;
        s2_erange_reg <= s1_erange_reg;
        s2_ealign_reg <= s1_ealign_reg;
      end

      if (s2_advance && (s2_erange_reg || s2_ealign_reg) && (cnt_reg != '1))
        cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign out_valid = s2_valid_reg;
  assign instr     = s2_instr_reg;
  assign err_range = s2_erange_reg;
  assign err_align = s2_ealign_reg;
  assign err_count = cnt_reg;

endmodule

// File: tb/tb_imm_encode.sv
// ---------------------------------------------------------------------------
// tb_imm_encode
//   Self-checking bench for imm_encode. A negedge monitor keeps a queue of
//   accepted requests and, for each delivered beat, decodes the produced
//   instruction with the standard RISC-V immediate decoding and compares it
//   with the sign-extended, truncated request immediate. Error flags are
//   predicted from the signed value range. A second instance with a 2-bit
//   counter shares the stimulus to exercise counter saturation.
// ---------------------------------------------------------------------------
module tb_imm_encode;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  immsrc;
  logic [31:0] imm;
  logic [24:0] base;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] instr;
  logic        err_range;
  logic        err_align;
  logic [15:0] err_count;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [24:0] s_instr;
  logic        s_err_range;
  logic        s_err_align;
  logic [1:0]  s_err_count;

  always #5 clk = ~clk;

  imm_encode #(.CNTWIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .immsrc(immsrc), .imm(imm), .base(base), .out_valid(out_valid),
    .out_ready(out_ready), .instr(instr), .err_range(err_range),
    .err_align(err_align), .err_count(err_count)
  );

  imm_encode #(.CNTWIDTH(2)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .immsrc(immsrc), .imm(imm), .base(base), .out_valid(s_out_valid),
    .out_ready(out_ready), .instr(s_instr), .err_range(s_err_range),
    .err_align(s_err_align), .err_count(s_err_count)
  );

  typedef struct {
    logic [1:0]  src;
    logic [31:0] imm;
    logic [24:0] base;
  } beat_t;

  beat_t q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    model_cnt = 0;
  logic        hold_prev = 1'b0;
  logic [24:0] prev_instr;
  logic        prev_er;
  logic        prev_ea;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Standard RISC-V immediate decode of a full 32-bit instruction.
  function automatic logic [31:0] decode(input logic [1:0] src, input logic [31:0] ins);
    case (src)
      2'd0:    return {{20{ins[31]}}, ins[31:20]};
      2'd1:    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      2'd2:    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      default: return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endcase
  endfunction

  // Immediate the hardware can actually carry: truncated to the field width,
  // sign-extended, with bit 0 dropped for branch/jump offsets.
  function automatic logic [31:0] carried(input logic [1:0] src, input logic [31:0] v);
    case (src)
      2'd0, 2'd1: return 32'($signed(v << 20) >>> 20);
      2'd2:       return 32'($signed(v << 19) >>> 19) & ~32'd1;
      default:    return 32'($signed(v << 11) >>> 11) & ~32'd1;
    endcase
  endfunction

  // Instruction bits owned by the immediate for each format.
  function automatic logic [31:0] imm_mask(input logic [1:0] src);
    case (src)
      2'd0:       return 32'hFFF0_0000;
      2'd1, 2'd2: return 32'hFE00_0F80;
      default:    return 32'hFFFF_F000;
    endcase
  endfunction

  function automatic logic exp_range(input logic [1:0] src, input logic [31:0] v);
    int s;
    s = int'($signed(v));
    case (src)
      2'd0, 2'd1: return !(s >= -2048 && s <= 2047);
      2'd2:       return !(s >= -4096 && s <= 4095);
      default:    return !(s >= -(1 << 20) && s <= (1 << 20) - 1);
    endcase
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      check("rst_in_ready", 32'(in_ready), 32'd0);
      q.delete();
      model_cnt = 0;
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_instr", 32'(instr), 32'(prev_instr));
        check("hold_err", 32'({err_range, err_align}), 32'({prev_er, prev_ea}));
      end
      check("err_count", 32'(err_count), 32'(model_cnt));
      check("sat_count", 32'(s_err_count), 32'((model_cnt > 3) ? 3 : model_cnt));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_beat", 32'(out_valid), 32'd0);
        end else begin
          beat_t b;
          logic [31:0] ins;
          logic er, ea;
          b   = q.pop_front();
          ins = {instr, 7'b0};
          er  = exp_range(b.src, b.imm);
          ea  = b.src[1] & b.imm[0];
          check("imm_field", decode(b.src, ins), carried(b.src, b.imm));
          check("passthru", ins & ~imm_mask(b.src), {b.base, 7'b0} & ~imm_mask(b.src));
          check("err_range", 32'(err_range), 32'(er));
          check("err_align", 32'(err_align), 32'(ea));
          $display("[TB] beat src=%0d imm=%08h base=%07h instr=%07h er=%0b ea=%0b",
                   b.src, b.imm, b.base, instr, err_range, err_align);
          if (er || ea) model_cnt = (model_cnt == 65535) ? model_cnt : model_cnt + 1;
        end
      end
      if (in_valid && in_ready) q.push_back('{immsrc, imm, base});
      hold_prev  = out_valid && !out_ready;
      prev_instr = instr;
      prev_er    = err_range;
      prev_ea    = err_align;
    end
  end

  // Single beat into an empty pipeline with out_ready high; verifies the
  // two-cycle latency and returns the delivered word.
  task automatic drive_one(input logic [1:0] src, input logic [31:0] v, input logic [24:0] b,
                           output logic [24:0] got, output logic er, output logic ea);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    immsrc    = src;
    imm       = v;
    base      = b;
    @(negedge clk);
    check("one_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_cycle2", 32'(out_valid), 32'd1);
    got = instr;
    er  = err_range;
    ea  = err_align;
    @(posedge clk); #1;
  endtask

  task automatic rand_beat();
    int k;
    immsrc = 2'($urandom_range(3));
    base   = 25'($urandom);
    case ($urandom_range(3))
      0: imm = $urandom;
      1: imm = 32'(int'($urandom_range(4095)) - 2048);
      2: begin
        case ($urandom_range(2))
          0: k = 11;
          1: k = 12;
          default: k = 20;
        endcase
        imm = 32'((1 << k) + int'($urandom_range(2)) - 1);
        if ($urandom_range(1) == 1) imm = -imm;
      end
      default: imm = 32'(int'($urandom_range(32'h3F_FFFF)) - 32'h20_0000);
    endcase
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=%0d exp=%0d", 0, 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [24:0] got;
    logic er, ea, acc, saw_drop;
    int b;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    immsrc = 2'd0; imm = '0; base = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_err_flags", 32'({err_range, err_align}), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // I: -4
    drive_one(2'b00, 32'hFFFF_FFFC, 25'h0, got, er, ea);
    check("dir_I_instr", 32'(got), 32'h01FF_8000);
    check("dir_I_err", 32'({er, ea}), 32'd0);

    // B: +4094 with all-ones template
    drive_one(2'b10, 32'h0000_0FFE, 25'h1FF_FFFF, got, er, ea);
    check("dir_B_instr", 32'(got), 32'h00FF_FFFF);
    check("dir_B_err", 32'({er, ea}), 32'd0);

    // J: out of range, then odd
    drive_one(2'b11, 32'h0010_0000, 25'h0, got, er, ea);
    check("dir_J_range", 32'({er, ea}), 32'b10);
    @(negedge clk);
    check("dir_J_cnt1", 32'(err_count), 32'd1);
    @(posedge clk); #1;
    drive_one(2'b11, 32'h0000_0003, 25'h0, got, er, ea);
    check("dir_J_align", 32'({er, ea}), 32'b01);
    @(negedge clk);
    check("dir_J_cnt2", 32'(err_count), 32'd2);
    @(posedge clk); #1;

    // Five more errored beats: wide counter reaches 7, 2-bit one pins at 3.
    for (int i = 0; i < 5; i++) drive_one(2'b11, 32'h0000_0005, 25'h0, got, er, ea);
    @(negedge clk);
    check("sat_stop", 32'(s_err_count), 32'd3);
    check("wide_cnt", 32'(err_count), 32'd7);
    @(posedge clk); #1;

    // Backpressure: four back-to-back beats, consumer stalls cycles 3-6.
    b = 0; saw_drop = 1'b0;
    for (int c = 0; c < 16; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (b < 4);
      immsrc    = 2'(b);
      imm       = 32'(b * 100 + 2);
      base      = 25'(b * 32'h12345);
      @(negedge clk);
      if (in_valid && !in_ready) saw_drop = 1'b1;
      if (in_valid && in_ready) b++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_ready_drop", 32'(saw_drop), 32'd1);
    check("bp_all_sent", 32'(b), 32'd4);
    @(negedge clk);
    check("bp_drained", 32'(q.size()), 32'd0);
    @(posedge clk); #1;

    // Randomised traffic with random backpressure.
    acc = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(3) != 0);
        rand_beat();
      end
      out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    check("rand_drained", 32'(q.size()), 32'd0);
    @(posedge clk); #1;

    // Reset with two beats in flight.
    out_ready = 1'b0;
    in_valid = 1'b1; immsrc = 2'b11; imm = 32'h0000_0001; base = 25'h1;
    @(posedge clk); #1;
    imm = 32'h0000_0010;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_cnt", 32'(err_count), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("no_stale", 32'(out_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
